// File: rtl/key_event_pkg.sv
// key_event_pkg
//   Shared definitions for the key event controller: USB HID keycodes the
//   controller reacts to, the jump FSM state type, parameter defaults and a
//   small keycode classifier.
//   No ports (package).
package key_event_pkg;

  localparam int unsigned HOLD_LONG_DEF   = 8;
  localparam int unsigned BUF_TIMEOUT_DEF = 6;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_P     = 8'h13;

  typedef enum logic [1:0] {
    JMP_IDLE = 2'd0,
    JMP_HELD = 2'd1,
    JMP_LONG = 2'd2
  } jump_state_e;

  typedef struct packed {
    logic jump;
    logic duck;
    logic start;
    logic pause;
  } key_class_t;

  function automatic logic is_jump(input logic [7:0] code);
    return (code == KEY_W) || (code == KEY_SPACE);
  endfunction

  function automatic key_class_t classify(input logic [7:0] code);
    key_class_t c;
    c.jump  = is_jump(code);
    c.duck  = (code == KEY_S);
    c.start = (code == KEY_ENTER);
    c.pause = (code == KEY_P);
    return c;
  endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// key_event_ctrl_if
//   Bundles the frame/keyboard inputs and the game-event outputs of the
//   key event controller.
//   master: drives frame_clk, keycode, jump_ack; observes the events.
//   slave : the controller; receives the inputs and drives frame_tick,
//           jump_req, jump_long, duck, start_pulse, pause_toggle.
interface key_event_ctrl_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       jump_ack;
  logic       frame_tick;
  logic       jump_req;
  logic       jump_long;
  logic       duck;
  logic       start_pulse;
  logic       pause_toggle;

  modport master (
    output frame_clk, keycode, jump_ack,
    input  frame_tick, jump_req, jump_long, duck, start_pulse, pause_toggle
  );

  modport slave (
    input  frame_clk, keycode, jump_ack,
    output frame_tick, jump_req, jump_long, duck, start_pulse, pause_toggle
  );
endinterface

// File: rtl/frame_tick_sync.sv
// frame_tick_sync
//   Brings the asynchronous VGA vertical sync into the Clk domain and turns
//   each rising edge into a single-cycle registered tick.
//   Ports:
//     Clk        in  system clock
//     Reset      in  synchronous active-high reset
//     frame_clk  in  VGA_VS, asynchronous to Clk
//     frame_tick out one-Clk pulse per frame_clk rising edge
//   Latency: frame_clk first sampled high at posedge N -> frame_tick is high
//   between posedges N+2 and N+3, so logic clocked at N+3 sees it.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync2_q, edge_q, tick_q;
  logic tick_d;

  assign tick_d = sync2_q & ~edge_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl
//   Per-frame keyboard event decoder for the game. Keycodes are sampled once
//   per frame tick; press edges are found against the previous frame's
//   sample. Jump presses raise a pending jump_req that the game acknowledges
//   or that expires after BUF_TIMEOUT frames; a jump key held HOLD_LONG
//   frames fires jump_long once.
//   Ports:
//     Clk    in  system clock
//     Reset  in  synchronous active-high reset
//     bus    key_event_ctrl_if.slave
//            in : frame_clk, keycode[7:0], jump_ack
//            out: frame_tick, jump_req, jump_long, duck, start_pulse,
//                 pause_toggle (all registered)
//
//   Jump FSM
//   state    | meaning
//   ---------+----------------------------------------------------------
//   JMP_IDLE | no jump key held at the last tick; waiting for a press edge
//   JMP_HELD | jump key held, counting frames toward a long jump
//   JMP_LONG | long jump already fired; waiting for release
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int unsigned HOLD_LONG   = HOLD_LONG_DEF,
  parameter int unsigned BUF_TIMEOUT = BUF_TIMEOUT_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  key_event_ctrl_if.slave  bus
);

  localparam int HOLD_W = (HOLD_LONG > 1) ? $clog2(HOLD_LONG) : 1;
  localparam int BUF_W  = (BUF_TIMEOUT > 0) ? $clog2(BUF_TIMEOUT + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LONG - 1);
  localparam logic [BUF_W-1:0]  BUF_MAX  = BUF_W'(BUF_TIMEOUT);

  logic tick;

  frame_tick_sync u_tick (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (bus.frame_clk),
    .frame_tick (tick)
  );

  jump_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [BUF_W-1:0]  buf_cnt_q, buf_cnt_d;
  logic [7:0]        prev_key_q, prev_key_d;
  logic              jump_req_q, jump_req_d;
  logic              jump_long_q, jump_long_d;
  logic              duck_q, duck_d;
  logic              start_q, start_d;
  logic              pause_q, pause_d;
  logic              frame_tick_q;

  key_class_t cur_c;
  logic       prev_jump, prev_start, prev_pause;
  logic       jump_press;

  assign cur_c      = classify(bus.keycode);
  assign prev_jump  = is_jump(prev_key_q);
  assign prev_start = (prev_key_q == KEY_ENTER);
  assign prev_pause = (prev_key_q == KEY_P);
  assign jump_press = cur_c.jump & ~prev_jump;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    buf_cnt_d   = buf_cnt_q;
    prev_key_d  = prev_key_q;
    jump_req_d  = jump_req_q;
    jump_long_d = 1'b0;
    duck_d      = duck_q;
    start_d     = 1'b0;
    pause_d     = 1'b0;

    // Ack only means something while a request is pending.
    if (jump_req_q && bus.jump_ack) begin
      jump_req_d = 1'b0;
    end

    if (tick) begin
      prev_key_d = bus.keycode;
      duck_d     = cur_c.duck;
      start_d    = cur_c.start & ~prev_start;
      pause_d    = cur_c.pause & ~prev_pause;

      // Timeout and a coincident ack both just clear the request.
      if (jump_req_q) begin
        if (buf_cnt_q != BUF_MAX) begin
          buf_cnt_d = buf_cnt_q + 1'b1;
        end
        if (buf_cnt_d == BUF_MAX) begin
          jump_req_d = 1'b0;
        end
      end

      unique case (state_q)
        JMP_IDLE: begin
          // A press while a request is still pending re-arms the same
          // request rather than queueing another one.
          if (jump_press) begin
            state_d    = JMP_HELD;
            jump_req_d = 1'b1;
            hold_cnt_d = '0;
            buf_cnt_d  = '0;
          end
        end
        JMP_HELD: begin
          if (!cur_c.jump) begin
            state_d = JMP_IDLE;
          end else begin
            if (hold_cnt_q != HOLD_MAX) begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
            if (hold_cnt_d == HOLD_MAX) begin
              state_d     = JMP_LONG;
              jump_long_d = 1'b1;
            end
          end
        end
        JMP_LONG: begin
          if (!cur_c.jump) begin
            state_d = JMP_IDLE;
          end
        end
        default: state_d = JMP_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= JMP_IDLE;
      hold_cnt_q   <= '0;
      buf_cnt_q    <= '0;
      prev_key_q   <= KEY_NONE;
      jump_req_q   <= 1'b0;
      jump_long_q  <= 1'b0;
      duck_q       <= 1'b0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      buf_cnt_q    <= buf_cnt_d;
      prev_key_q   <= prev_key_d;
      jump_req_q   <= jump_req_d;
      jump_long_q  <= jump_long_d;
      duck_q       <= duck_d;
      start_q      <= start_d;
      pause_q      <= pause_d;
      frame_tick_q <= 1'b0;
    end
  end

  // frame_tick comes straight from the sync register; frame_tick_q is not
  // used for the output so the tick latency stays at the sync stage.
  assign bus.frame_tick   = tick | frame_tick_q;
  assign bus.jump_req     = jump_req_q;
  assign bus.jump_long    = jump_long_q;
  assign bus.duck         = duck_q;
  assign bus.start_pulse  = start_q;
  assign bus.pause_toggle = pause_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
module tb_key_event_ctrl;

  localparam int HL = 8;
  localparam int BT = 6;

  logic Clk = 1'b0;
  logic Reset;

  key_event_ctrl_if bus ();

  key_event_ctrl #(.HOLD_LONG(HL), .BUF_TIMEOUT(BT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_tick   = 0;
  int n_long   = 0;
  int n_start  = 0;
  int n_pause  = 0;
  int n_frames = 0;
  int req_hi   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (bus.frame_tick)   n_tick  <= n_tick + 1;
    if (bus.jump_long)    n_long  <= n_long + 1;
    if (bus.start_pulse)  n_start <= n_start + 1;
    if (bus.pause_toggle) n_pause <= n_pause + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame-level reference model
  typedef struct packed {
    logic req;
    logic lng;
    logic duck;
    logic start;
    logic pause;
  } exp_t;

  exp_t       sb_q[$];
  int         m_state;
  int         m_hold;
  int         m_buf;
  bit         m_req;
  logic [7:0] m_prev;

  function automatic bit jumpk(input logic [7:0] k);
    return (k == 8'h1A) || (k == 8'h2C);
  endfunction

  task automatic model_reset();
    m_state = 0; m_hold = 0; m_buf = 0; m_req = 0; m_prev = 8'h00;
    sb_q.delete();
  endtask

  task automatic model_frame(input logic [7:0] kc, input bit ack);
    exp_t e;
    bit jn, jp;
    jn = jumpk(kc);
    jp = jumpk(m_prev);
    e = '0;
    e.start = (kc == 8'h28) && (m_prev != 8'h28);
    e.pause = (kc == 8'h13) && (m_prev != 8'h13);
    e.duck  = (kc == 8'h16);
    if (m_req) begin
      if (m_buf < BT) m_buf++;
      if (m_buf == BT || ack) m_req = 0;
    end
    if (m_state == 0) begin
      if (jn && !jp) begin
        m_state = 1; m_req = 1; m_buf = 0; m_hold = 0;
      end
    end else if (!jn) begin
      m_state = 0;
    end else if (m_state == 1) begin
      if (m_hold < HL - 1) m_hold++;
      if (m_hold == HL - 1) begin
        m_state = 2;
        e.lng = 1'b1;
      end
    end
    m_prev = kc;
    e.req = m_req;
    sb_q.push_back(e);
  endtask

  // ackmode: 0 none, 1 ack during the tick cycle, 2 ack 2 cycles after the
  // outputs update.
  task automatic do_frame(input logic [7:0] kc, input int ackmode);
    int d, first_pos, tick_pos;
    bit seen;
    exp_t e;
    @(negedge Clk);
    bus.keycode = kc;
    d = $urandom_range(1, 8);
    if (d >= 5) d++;
    #d;
    first_pos = cyc + 1;  // first posedge that samples frame_clk=1
    bus.frame_clk = 1'b1;
    n_frames++;
    seen = 0;
    tick_pos = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge Clk);
      if (bus.frame_tick) begin
        seen = 1;
        tick_pos = cyc;
      end
    end
    if (!seen) begin
      chk("tick_timeout", 32'd0, 32'd1);
      bus.frame_clk = 1'b0;
      repeat (8) @(negedge Clk);
      return;
    end
    // Tick register loads at posedge first+2, so it is seen at posedge first+3.
    chk("tick_latency", tick_pos - first_pos, 32'd2);
    if (ackmode == 1) bus.jump_ack = 1'b1;
    model_frame(kc, ackmode == 1);
    @(negedge Clk);
    bus.jump_ack = 1'b0;
    e = sb_q.pop_front();
    if (bus.jump_req) req_hi++;
    chk("jump_req",   bus.jump_req,     e.req);
    chk("jump_long",  bus.jump_long,    e.lng);
    chk("duck",       bus.duck,         e.duck);
    chk("start",      bus.start_pulse,  e.start);
    chk("pause",      bus.pause_toggle, e.pause);
    chk("tick_width", bus.frame_tick,   1'b0);
    @(negedge Clk);
    chk("pulse_width", {bus.jump_long, bus.start_pulse, bus.pause_toggle}, 3'b000);
    chk("duck_hold",   bus.duck, e.duck);
    if (ackmode == 2) begin
      @(negedge Clk);
      bus.jump_ack = 1'b1;
      m_req = 0;
      @(negedge Clk);
      bus.jump_ack = 1'b0;
      chk("ack_clear", bus.jump_req, m_req);
    end
    bus.frame_clk = 1'b0;
    repeat (8) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_outputs", {bus.frame_tick, bus.jump_req, bus.jump_long, bus.duck,
                        bus.start_pulse, bus.pause_toggle}, 6'd0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, s2;
    Reset = 1'b1;
    bus.frame_clk = 1'b0;
    bus.keycode   = 8'h00;
    bus.jump_ack  = 1'b0;
    model_reset();
    do_reset();

    // idle frames at random phase
    repeat (4) do_frame(8'h00, 0);

    // single Space tap, no ack: pending 6 ticks then timeout
    s0 = n_long; s1 = req_hi;
    do_frame(8'h2C, 0);
    repeat (8) do_frame(8'h00, 0);
    chk("tap_no_long",   n_long - s0, 0);
    chk("tap_req_ticks", req_hi - s1, 6);

    // W held 10 ticks, ack 2 cycles after request
    s0 = n_long;
    do_frame(8'h1A, 2);
    repeat (9) do_frame(8'h1A, 0);
    do_frame(8'h00, 0);
    chk("hold_long_once", n_long - s0, 1);

    // re-press while pending restarts the timeout
    do_frame(8'h2C, 0);
    do_frame(8'h00, 0);
    do_frame(8'h1A, 0);
    repeat (7) do_frame(8'h00, 0);

    // Enter x5 then P x3, then duck
    s0 = n_start; s1 = n_pause;
    repeat (5) do_frame(8'h28, 0);
    repeat (3) do_frame(8'h13, 0);
    do_frame(8'h00, 0);
    chk("start_once", n_start - s0, 1);
    chk("pause_once", n_pause - s1, 1);
    repeat (2) do_frame(8'h16, 0);
    do_frame(8'h33, 0);

    // ack coincident with the timeout tick, then a fresh request
    do_frame(8'h2C, 0);
    repeat (5) do_frame(8'h00, 0);
    do_frame(8'h00, 1);
    do_frame(8'h2C, 0);
    repeat (6) do_frame(8'h00, 0);

    // reset with request pending and key held, then fresh press
    s2 = req_hi;
    do_frame(8'h1A, 0);
    do_frame(8'h1A, 0);
    do_reset();
    do_frame(8'h1A, 0);
    chk("fresh_req_after_rst", req_hi - s2, 3);
    repeat (2) do_frame(8'h00, 0);

    chk("tick_count", n_tick, n_frames);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter HOLD_LONG, default 8, frames a jump key must stay held before jump_long fires.
REQ-002 SHALL have parameter BUF_TIMEOUT, default 6, frames an unacknowledged jump_req stays pending.
REQ-003 SHALL have port Clk, input, 1, single system clock (50 MHz); all logic on posedge Clk.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port frame_clk, input, 1, VGA_VS, asynchronous to Clk; a new frame begins on its rising edge.
REQ-006 SHALL have port keycode, input, 8, USB HID keycode from the soft core PIO; 0x00 means no key.
REQ-007 SHALL have port jump_ack, input, 1, game logic has consumed jump_req.
REQ-008 SHALL have port frame_tick, output, 1, one-Clk pulse per frame.
REQ-009 SHALL have port jump_req, output, 1, pending jump request, held until acknowledged or timed out.
REQ-010 SHALL have port jump_long, output, 1, one-Clk pulse when a jump key is held HOLD_LONG frames.
REQ-011 SHALL have port duck, output, 1, level: duck key down at the last frame_tick.
REQ-012 SHALL have port start_pulse, output, 1, one-Clk pulse on an Enter press edge.
REQ-013 SHALL have port pause_toggle, output, 1, one-Clk pulse on a P press edge.

Function
REQ-014 Tick generation SHALL use a 2-flop synchroniser on frame_clk plus an edge register; frame_tick SHALL be a registered pulse, high exactly 1 Clk on the 3rd posedge after the first posedge that samples frame_clk=1.
REQ-015 keycode SHALL be sampled only in a cycle where frame_tick=1; all key decisions use that sample and the previous frame's sample (prev_key, reset 0x00).
REQ-016 Key map: jump = 0x1A (W) or 0x2C (Space); duck = 0x16 (S); start = 0x28 (Enter); pause = 0x13 (P); all other codes are ignored.
REQ-017 A press edge SHALL be current sample in the class and prev_key not in the same class; holding a key SHALL never retrigger.
REQ-018 start_pulse and pause_toggle SHALL assert in the Clk cycle after the sampling frame_tick, for 1 cycle.
REQ-019 duck SHALL update in the Clk cycle after each frame_tick and hold between ticks.
REQ-020 Jump FSM states: IDLE, HELD, LONG.
  - IDLE -> HELD on a jump press edge: set jump_req, clear hold_cnt and buf_cnt.
  - HELD: hold_cnt +1 per tick while the jump key is still sampled; at hold_cnt = HOLD_LONG-1 the transition to LONG pulses jump_long once.
  - HELD/LONG -> IDLE on the first tick where the jump key is not sampled.
REQ-021 jump_req handshake:
  - set as in REQ-020; clear on the cycle after jump_ack=1.
  - buf_cnt +1 per tick while pending; clear jump_req when buf_cnt reaches BUF_TIMEOUT.
  - jump_ack is ignored while jump_req=0.
REQ-022 jump_ack in the same cycle as a timeout SHALL count as acknowledged; both clear jump_req, with no error.
REQ-023 A new jump press edge while jump_req is pending SHALL restart buf_cnt and not queue a second request.
REQ-024 hold_cnt SHALL saturate at HOLD_LONG-1; buf_cnt SHALL saturate at BUF_TIMEOUT; neither wraps.
REQ-025 All outputs SHALL be registered; no combinational path from keycode or jump_ack to any output.

Reset
REQ-026 Reset=1 SHALL clear in the next cycle:
  - all outputs to 0;
  - FSM to IDLE;
  - hold_cnt, buf_cnt, synchroniser flops and prev_key to 0.
REQ-027 Reset mid-operation SHALL drop any pending jump_req; a key still held after reset SHALL produce a fresh press edge at the first tick.

Structure
REQ-028 Package key_event_pkg SHALL hold the keycode constants, the jump FSM enum, and the HOLD_LONG and BUF_TIMEOUT defaults.
REQ-029 The synchroniser and edge logic SHALL be the sub-module frame_tick_sync (Clk, Reset, frame_clk -> frame_tick).

Verification
REQ-030 Toggle frame_clk at 60 Hz-equivalent with random phase -> exactly one frame_tick per rising edge, at the REQ-014 latency.
REQ-031 keycode=0x2C for 1 tick then 0x00, no ack -> jump_req high for 6 ticks then low; jump_long never asserts.
REQ-032 keycode=0x1A held 10 ticks, jump_ack 2 cycles after jump_req -> jump_req clears next cycle; exactly one jump_long at the 8th held tick; no re-request.
REQ-033 keycode 0x28 for 5 ticks, then 0x13 for 3 ticks -> exactly one start_pulse and one pause_toggle, each 1 Clk wide.
REQ-034 jump_ack coincident with the timeout tick -> jump_req low next cycle, FSM consistent; Reset asserted with jump_req pending and key held -> all outputs 0, then a fresh jump_req at the first tick after release of Reset.
